// File: rtl/player_mover_if.sv
// Player mover bus: frame tick, wall map and key requests in; committed position and status out.
// Tile[row][col] is packed with col 0 as the MSB of each row.
interface player_mover_if;
    logic                frame_tick;
    logic [0:29][0:39]   Tile;
    logic                key_up;
    logic                key_down;
    logic                key_left;
    logic                key_right;
    logic [9:0]          Player_X;
    logic [9:0]          Player_Y;
    logic                busy;
    logic                move_done;
    logic                blocked;

    modport master (
        output frame_tick, Tile, key_up, key_down, key_left, key_right,
        input  Player_X, Player_Y, busy, move_done, blocked
    );

    modport slave (
        input  frame_tick, Tile, key_up, key_down, key_left, key_right,
        output Player_X, Player_Y, busy, move_done, blocked
    );
endinterface

// File: rtl/player_mover.sv
// Per-frame move + four-corner wall check; fixed 7-cycle sequence from tick to committed position.
// No backpressure: ticks arriving while busy are dropped, keys are sampled only on the accepted tick.
module player_mover #(
    parameter int BALL_SIZE = 8,
    parameter int STEP      = 1,
    parameter int START_X   = 24,
    parameter int START_Y   = 24,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480
) (
    input  logic           Clk,
    input  logic           Reset_n,
    player_mover_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_C0,
        S_C1,
        S_C2,
        S_C3,
        S_RESOLVE
    } state_t;

    typedef enum logic [1:0] {
        D_UP,
        D_DOWN,
        D_LEFT,
        D_RIGHT
    } dir_t;

    localparam logic signed [10:0] L_STEP    = 11'(STEP);
    localparam logic signed [10:0] L_MAX_X   = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] L_MAX_Y   = 11'(SCREEN_H - BALL_SIZE);
    localparam logic        [9:0]  L_EDGE    = 10'(BALL_SIZE - 1);
    localparam logic        [9:0]  L_START_X = 10'(START_X);
    localparam logic        [9:0]  L_START_Y = 10'(START_Y);

    state_t      r_state;
    dir_t        r_dir;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [9:0]  r_cx;
    logic [9:0]  r_cy;
    logic        r_hit;
    logic        r_busy;
    logic        r_done;
    logic        r_blocked;

    logic              w_key_any;
    dir_t              w_dir_sel;
    logic signed [10:0] w_x_s;
    logic signed [10:0] w_y_s;
    logic signed [10:0] w_up;
    logic signed [10:0] w_down;
    logic signed [10:0] w_left;
    logic signed [10:0] w_right;
    logic [9:0]        w_cand_x;
    logic [9:0]        w_cand_y;
    logic [9:0]        w_corner_x;
    logic [9:0]        w_corner_y;
    logic [5:0]        w_row;
    logic [5:0]        w_col;
    logic              w_wall;

    assign w_key_any = bus.key_up | bus.key_down | bus.key_left | bus.key_right;

    always_comb begin
        w_dir_sel = D_RIGHT;
        if (bus.key_up)        w_dir_sel = D_UP;
        else if (bus.key_down) w_dir_sel = D_DOWN;
        else if (bus.key_left) w_dir_sel = D_LEFT;
    end

    // One bit of headroom so stepping below zero stays negative instead of wrapping.
    assign w_x_s   = signed'({1'b0, r_x});
    assign w_y_s   = signed'({1'b0, r_y});
    assign w_up    = w_y_s - L_STEP;
    assign w_down  = w_y_s + L_STEP;
    assign w_left  = w_x_s - L_STEP;
    assign w_right = w_x_s + L_STEP;

    always_comb begin
        w_cand_x = r_x;
        w_cand_y = r_y;
        case (r_dir)
            D_UP:    w_cand_y = (w_up < 11'sd0)      ? 10'd0         : w_up[9:0];
            D_DOWN:  w_cand_y = (w_down > L_MAX_Y)   ? L_MAX_Y[9:0]  : w_down[9:0];
            D_LEFT:  w_cand_x = (w_left < 11'sd0)    ? 10'd0         : w_left[9:0];
            default: w_cand_x = (w_right > L_MAX_X)  ? L_MAX_X[9:0]  : w_right[9:0];
        endcase
    end

    // C1/C3 probe the right edge, C2/C3 the bottom edge of the candidate box.
    assign w_corner_x = r_cx + (((r_state == S_C1) || (r_state == S_C3)) ? L_EDGE : 10'd0);
    assign w_corner_y = r_cy + (((r_state == S_C2) || (r_state == S_C3)) ? L_EDGE : 10'd0);
    assign w_row      = w_corner_y[9:4];
    assign w_col      = w_corner_x[9:4];
    assign w_wall     = ((w_row < 6'd30) && (w_col < 6'd40)) ? bus.Tile[w_row[4:0]][w_col] : 1'b1;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_dir     <= D_UP;
            r_x       <= L_START_X;
            r_y       <= L_START_Y;
            r_cx      <= L_START_X;
            r_cy      <= L_START_Y;
            r_hit     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_blocked <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.frame_tick && w_key_any) begin
                        r_dir   <= w_dir_sel;
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_cx    <= w_cand_x;
                    r_cy    <= w_cand_y;
                    r_hit   <= 1'b0;
                    r_state <= S_C0;
                end
                S_C0: begin
                    r_hit   <= r_hit | w_wall;
                    r_state <= S_C1;
                end
                S_C1: begin
                    r_hit   <= r_hit | w_wall;
                    r_state <= S_C2;
                end
                S_C2: begin
                    r_hit   <= r_hit | w_wall;
                    r_state <= S_C3;
                end
                S_C3: begin
                    r_hit     <= r_hit | w_wall;
                    r_done    <= 1'b1;
                    r_blocked <= r_hit | w_wall;
                    r_state   <= S_RESOLVE;
                end
                S_RESOLVE: begin
                    if (!r_hit) begin
                        r_x <= r_cx;
                        r_y <= r_cy;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Player_X  = r_x;
    assign bus.Player_Y  = r_y;
    assign bus.busy      = r_busy;
    assign bus.move_done = r_done;
    assign bus.blocked   = r_blocked;

endmodule
